// File: rtl/icg_bank_pkg.sv
// icg_bank_pkg: shared constants, hold-off counter type and the enable OR-reduction helper
package icg_bank_pkg;

    localparam int HW_DEFAULT = 4;
    localparam int NCH_MAX    = 32;

    typedef logic [HW_DEFAULT-1:0] hold_cnt_t;

    // Any channel functionally active; callers zero-extend their enable vector to NCH_MAX.
    function automatic logic any_on(input logic [NCH_MAX-1:0] v);
        return |v;
    endfunction

endpackage

// File: rtl/icg_lat_and.sv
// icg_lat_and: negative-level latch plus AND, one glitch-free clock gate
//   clk : source clock
//   d   : gate enable, captured while clk is low
//   q   : gated clock, clk AND latched enable
module icg_lat_and (
    input  logic clk,
    input  logic d,
    output logic q
);

    logic iq;

    // Transparent only in the low phase, so the enable cannot change under a high pulse.
    always_latch
        if (!clk) iq <= d;

    assign q = clk & iq;

endmodule

// File: rtl/icg_bank_hyst.sv
// icg_bank_hyst: bank of NCH clock gates, each with a programmable hold-off before gating off
//   CLK     : source clock
//   RN      : asynchronous active-low reset
//   E       : per-channel functional enable, sampled on rising CLK
//   TE      : test enable, forces every gate open without touching the counters
//   HOLD    : hold-off cycle count, loaded on each enable sample
//   Q       : gated clocks
//   ACT     : registered per-channel enable state
//   ANY_ACT : OR of ACT
module icg_bank_hyst
    import icg_bank_pkg::*;
#(
    parameter int NCH = 4,
    parameter int HW  = HW_DEFAULT
) (
    input  logic           CLK,
    input  logic           RN,
    input  logic [NCH-1:0] E,
    input  logic           TE,
    input  logic [HW-1:0]  HOLD,
    output logic [NCH-1:0] Q,
    output logic [NCH-1:0] ACT,
    output logic           ANY_ACT
);

    for (genvar g = 0; g < NCH; g++) begin : ch
        logic [HW-1:0] cnt;
        logic          en_q;
        // An enable sample always reloads, so a retrigger while counting never drops the clock.
        always_ff @(posedge CLK or negedge RN)
            if (!RN) begin
                cnt  <= '0;
                en_q <= 1'b0;
            end else if (E[g]) begin
                cnt  <= HOLD;
                en_q <= 1'b1;
            end else if (cnt != '0) begin
                cnt  <= cnt - HW'(1);
            end else begin
                en_q <= 1'b0;
            end
        icg_lat_and u_icg (
            .clk (CLK),
            .d   (en_q | TE),
            .q   (Q[g])
        );
        assign ACT[g] = en_q;
    end

    assign ANY_ACT = any_on(NCH_MAX'(ACT));

endmodule

// File: tb/tb_icg_bank_hyst.sv
// tb_icg_bank_hyst: directed scoreboard bench for icg_bank_hyst
module tb_icg_bank_hyst;

    localparam int NCH = 4;
    localparam int HW  = 4;

    typedef struct {
        logic [NCH-1:0] q;
        logic [NCH-1:0] act;
        bit             mid;
    } exp_t;

    logic           CLK = 1'b0;
    logic           RN  = 1'b1;
    logic [NCH-1:0] E   = '1;
    logic           TE  = 1'b0;
    logic [HW-1:0]  HOLD = '0;
    logic [NCH-1:0] Q;
    logic [NCH-1:0] ACT;
    logic           ANY_ACT;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   q1_pulses = 0;

    icg_bank_hyst #(.NCH(NCH), .HW(HW)) dut (
        .CLK     (CLK),
        .RN      (RN),
        .E       (E),
        .TE      (TE),
        .HOLD    (HOLD),
        .Q       (Q),
        .ACT     (ACT),
        .ANY_ACT (ANY_ACT)
    );

    always #5 CLK = ~CLK;

    always @(posedge Q[1]) q1_pulses++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h, required %0h", name, $time, act, req);
        end
    endtask

    // Drive one cycle in the low phase and queue what the next rising edge must show.
    task automatic step(input logic [NCH-1:0] e, input logic te, input logic [HW-1:0] hold,
                        input logic rn, input bit pulse,
                        input logic [NCH-1:0] exp_q, input logic [NCH-1:0] exp_act);
        exp_t r;
        @(negedge CLK);
        E = e;
        TE = te;
        HOLD = hold;
        RN = rn;
        r.q = exp_q;
        r.act = exp_act;
        r.mid = pulse;
        sb.push_back(r);
        if (pulse) begin
            @(posedge CLK);
            #2 RN = 1'b0;
        end
    endtask

    // Monitor: outputs at edge+1, optional mid-high reset check at edge+3, Q stability at edge+4.
    always @(posedge CLK) begin
        logic [NCH-1:0] qh;
        exp_t r;
        #1;
        qh = Q;
        if (sb.size() > 0) begin
            r = sb.pop_front();
            chk("q", 32'(Q), 32'(r.q));
            chk("act", 32'(ACT), 32'(r.act));
            chk("any_act", 32'(ANY_ACT), 32'(|r.act));
            if (r.mid) begin
                #2;
                chk("act_async_clear", 32'(ACT), 32'(0));
                chk("any_act_async_clear", 32'(ANY_ACT), 32'(0));
                #1;
            end else begin
                #3;
            end
        end else begin
            #3;
        end
        chk("q_stable_high", 32'(Q), 32'(qh));
    end

    initial begin
        #1 RN = 1'b0;
        // reset holds everything off despite E all ones
        step(4'b1111, 0, 0, 0, 0, 4'b0000, 4'b0000);
        step(4'b1111, 0, 0, 0, 0, 4'b0000, 4'b0000);
        // release: first sample arms ch0, pulse on the following edge
        step(4'b0001, 0, 0, 1, 0, 4'b0000, 4'b0001);
        step(4'b0000, 0, 3, 1, 0, 4'b0001, 4'b0000);
        step(4'b0000, 0, 3, 1, 0, 4'b0000, 4'b0000);
        // HOLD=3 on ch1: four pulses, ACT falls four edges after the sample
        q1_pulses = 0;
        step(4'b0010, 0, 3, 1, 0, 4'b0000, 4'b0010);
        step(4'b0000, 0, 3, 1, 0, 4'b0010, 4'b0010);
        step(4'b0000, 0, 3, 1, 0, 4'b0010, 4'b0010);
        step(4'b0000, 0, 3, 1, 0, 4'b0010, 4'b0010);
        step(4'b0000, 0, 3, 1, 0, 4'b0010, 4'b0000);
        step(4'b0000, 0, 3, 1, 0, 4'b0000, 4'b0000);
        @(negedge CLK);
        chk("q1_pulse_count", 32'(q1_pulses), 32'd4);
        // HOLD=0 on ch2 toggled: pulses on alternate edges
        step(4'b0100, 0, 0, 1, 0, 4'b0000, 4'b0100);
        step(4'b0000, 0, 0, 1, 0, 4'b0100, 4'b0000);
        step(4'b0100, 0, 0, 1, 0, 4'b0000, 4'b0100);
        step(4'b0000, 0, 0, 1, 0, 4'b0100, 4'b0000);
        step(4'b0000, 0, 0, 1, 0, 4'b0000, 4'b0000);
        // HOLD=5 on ch0, retrigger at cnt=1 reloads to 5: eleven continuous pulses
        step(4'b0001, 0, 5, 1, 0, 4'b0000, 4'b0001);
        for (int i = 0; i < 4; i++) step(4'b0000, 0, 5, 1, 0, 4'b0001, 4'b0001);
        step(4'b0001, 0, 5, 1, 0, 4'b0001, 4'b0001);
        for (int i = 0; i < 5; i++) step(4'b0000, 0, 5, 1, 0, 4'b0001, 4'b0001);
        step(4'b0000, 0, 5, 1, 0, 4'b0001, 4'b0000);
        step(4'b0000, 0, 5, 1, 0, 4'b0000, 4'b0000);
        // HOLD=1 on ch3, enable at the edge where cnt reaches 0 reloads without a drop
        step(4'b1000, 0, 1, 1, 0, 4'b0000, 4'b1000);
        step(4'b0000, 0, 1, 1, 0, 4'b1000, 4'b1000);
        step(4'b1000, 0, 1, 1, 0, 4'b1000, 4'b1000);
        step(4'b0000, 0, 1, 1, 0, 4'b1000, 4'b1000);
        step(4'b0000, 0, 1, 1, 0, 4'b1000, 4'b0000);
        step(4'b0000, 0, 1, 1, 0, 4'b0000, 4'b0000);
        // TE override: all gates open, ACT untouched, closed again right after
        for (int i = 0; i < 6; i++) step(4'b0000, 1, 0, 1, 0, 4'b1111, 4'b0000);
        step(4'b0000, 0, 0, 1, 0, 4'b0000, 4'b0000);
        // HOLD=7 on ch1, async reset in the high phase when cnt=4
        step(4'b0010, 0, 7, 1, 0, 4'b0000, 4'b0010);
        step(4'b0000, 0, 7, 1, 0, 4'b0010, 4'b0010);
        step(4'b0000, 0, 7, 1, 0, 4'b0010, 4'b0010);
        step(4'b0000, 0, 7, 1, 1, 4'b0010, 4'b0010);
        step(4'b0000, 0, 7, 1, 0, 4'b0000, 4'b0000);
        step(4'b0000, 0, 7, 1, 0, 4'b0000, 4'b0000);
        repeat (3) @(negedge CLK);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
